cmult_stream: RTL

CMULT_STREAM -- requirements
Module: cmult_stream

---
 rtl/cmult_stream.sv | 136 +++++++++++++
 1 files changed

// File: rtl/cmult_stream.sv
`default_nettype none
// ============================================================================
// Module : cmult_stream
// Streaming complex multiplier, a*b or a*conj(b), 4-stage valid/ready pipeline
// Rev    : 1.0
// ============================================================================
module cmult_stream #(
  parameter int N  = 8,
  parameter int TW = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [N-1:0]   a_r,
  input  logic signed [N-1:0]   a_i,
  input  logic signed [N-1:0]   b_r,
  input  logic signed [N-1:0]   b_i,
  input  logic                  conj,
  input  logic        [TW-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [2*N:0]   c_r,
  output logic signed [2*N:0]   c_i,
  output logic        [TW-1:0]  out_tag
);

  localparam int c_WE = N + 1;
  localparam int c_WS = N + 2;
  localparam int c_WP = 2 * N + 4;
  localparam int c_WO = 2 * N + 1;

  // Stage 0: extended operands and pre-adds
  logic                   r0_valid;
  logic [TW-1:0]          r0_tag;
  logic signed [c_WE-1:0] r0_ar, r0_ai, r0_br, r0_bi;
  logic signed [c_WS-1:0] r0_sa, r0_sb;
  // Stage 1: three partial products
  logic                   r1_valid;
  logic [TW-1:0]          r1_tag;
  logic signed [c_WP-1:0] r1_p1, r1_p2, r1_p3;
  // Stage 2: post-subtracts
  logic                   r2_valid;
  logic [TW-1:0]          r2_tag;
  logic signed [c_WP-1:0] r2_r, r2_t, r2_p2;
  // Stage 3: output registers
  logic                   r3_valid;
  logic [TW-1:0]          r3_tag;
  logic signed [c_WO-1:0] r3_cr, r3_ci;

  logic                   w_adv;
  logic signed [c_WE-1:0] w_ar, w_ai, w_br, w_bi_raw, w_bi;
  logic signed [c_WS-1:0] w_sa, w_sb;
  logic signed [c_WP-1:0] w_p1, w_p2, w_p3, w_ci;
  logic                   w_unused;

  assign w_adv    = !r3_valid || out_ready;
  assign in_ready = w_adv;

  assign w_ar     = {a_r[N-1], a_r};
  assign w_ai     = {a_i[N-1], a_i};
  assign w_br     = {b_r[N-1], b_r};
  assign w_bi_raw = {b_i[N-1], b_i};
  // One extra bit makes negating -2^(N-1) exact
  assign w_bi     = conj ? -w_bi_raw : w_bi_raw;
  assign w_sa     = {w_ar[c_WE-1], w_ar} + {w_ai[c_WE-1], w_ai};
  assign w_sb     = {w_br[c_WE-1], w_br} + {w_bi[c_WE-1], w_bi};

  assign w_p1 = c_WP'(r0_ar) * c_WP'(r0_br);
  assign w_p2 = c_WP'(r0_ai) * c_WP'(r0_bi);
  assign w_p3 = c_WP'(r0_sa) * c_WP'(r0_sb);
  assign w_ci = r2_t - r2_p2;

  // Exact results always fit in 2N+1 bits, so upper bits are pure sign copies
  assign w_unused = &{1'b0, r2_r[c_WP-1:c_WO], w_ci[c_WP-1:c_WO]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r0_valid <= 1'b0;
      r0_tag   <= '0;
      r0_ar    <= '0;
      r0_ai    <= '0;
      r0_br    <= '0;
      r0_bi    <= '0;
      r0_sa    <= '0;
      r0_sb    <= '0;
      r1_valid <= 1'b0;
      r1_tag   <= '0;
      r1_p1    <= '0;
      r1_p2    <= '0;
      r1_p3    <= '0;
      r2_valid <= 1'b0;
      r2_tag   <= '0;
      r2_r     <= '0;
      r2_t     <= '0;
      r2_p2    <= '0;
      r3_valid <= 1'b0;
      r3_tag   <= '0;
      r3_cr    <= '0;
      r3_ci    <= '0;
    end else if (w_adv) begin
      r0_valid <= in_valid;
      r0_tag   <= in_tag;
      r0_ar    <= w_ar;
      r0_ai    <= w_ai;
      r0_br    <= w_br;
      r0_bi    <= w_bi;
      r0_sa    <= w_sa;
      r0_sb    <= w_sb;

      r1_valid <= r0_valid;
      r1_tag   <= r0_tag;
      r1_p1    <= w_p1;
      r1_p2    <= w_p2;
      r1_p3    <= w_p3;

      r2_valid <= r1_valid;
      r2_tag   <= r1_tag;
      r2_r     <= r1_p1 - r1_p2;
      r2_t     <= r1_p3 - r1_p1;
      r2_p2    <= r1_p2;

      r3_valid <= r2_valid;
      r3_tag   <= r2_tag;
      r3_cr    <= r2_r[c_WO-1:0];
      r3_ci    <= w_ci[c_WO-1:0];
    end
  end

  assign out_valid = r3_valid;
  assign out_tag   = r3_tag;
  assign c_r       = r3_cr;
  assign c_i       = r3_ci;

endmodule
`default_nettype wire
